sha_fsm: RTL and testbench
==========================

Name: sha_fsm

Overview:
Control-group sequencer for one SHA accelerator. It accepts a hash request (source address, destination address, control bits) from the request queue and wins the shared data bus through the bus arbiter. It then issues a memory-read command, waits for the transfer and for hash completion, and issues a write-back command. Finally it posts the destination address to the completion queue.

Parameters:
ADDRW, 24, address width in bits.
ACCEL_ID, 2'b01, 2-bit accelerator ID placed in every bus command header.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-high reset (1 = reset). The name is kept for codebase compatibility.
req_valid  in  1  request queue has a request.
req_data  in  2*ADDRW+2  bits [2*ADDRW+1:2*ADDRW] = ctrl, [2*ADDRW-1:ADDRW] = dest addr, [ADDRW-1:0] = src addr.
ready_req_out  out  1  FSM can accept a request.
comq_ready_in  in  1  completion queue can accept an entry.
compq_data_out  out  ADDRW  completed request's dest addr.
valid_compq_out  out  1  completion entry valid.
arb_req  out  1  bus request to the arbiter.
arb_grant  in  1  bus grant from the arbiter.
ack_in  in  3  bit0 = memory read transfer done; bit1 = SHA hash done; bit2 = memory write-back done.
data_out  out  ADDRW+8  bus command = {header[7:0], addr[ADDRW-1:0]}.

Behaviour:
- Header layout: [7:6] opcode (2'b01 MEM_READ, 2'b10 MEM_WRITE), [5:4] ACCEL_ID, [3:2] latched ctrl, [1:0] 2'b00.
- States: IDLE, RD_ARB, RD_SEND, RD_WAIT, HASH_WAIT, WR_ARB, WR_SEND, WR_WAIT, COMPLETE.
- Outputs are Moore, decoded from the state and the latched registers.
- IDLE:
  - ready_req_out=1.
  - On req_valid=1, latch src, dest and ctrl, then go to RD_ARB.
- RD_ARB: arb_req=1. On arb_grant=1, go to RD_SEND; otherwise stay.
- RD_SEND, exactly 1 cycle: arb_req=1 and data_out={2'b01,ACCEL_ID,ctrl,2'b00,src}. Then go to RD_WAIT.
- RD_WAIT: on ack_in[0]=1, go to HASH_WAIT.
- HASH_WAIT: on ack_in[1]=1, go to WR_ARB.
- WR_ARB / WR_SEND: same as the read pair, but data_out={2'b10,ACCEL_ID,ctrl,2'b00,dest}. Then go to WR_WAIT.
- WR_WAIT: on ack_in[2]=1, go to COMPLETE.
- COMPLETE:
  - valid_compq_out=1 and compq_data_out=dest, held stable.
  - On comq_ready_in=1, go to IDLE (the handshake completes that cycle).
- Default output values: data_out=0 outside the SEND states; compq_data_out=0 outside COMPLETE; arb_req=0 outside the ARB and SEND states.
- arb_grant is sampled only in ARB states. The arbiter holds the grant while arb_req is high.
- ack bits are sampled only in their own wait state; other bits, and acks arriving early, are ignored (not stored). Several ack bits high at once: only the current state's bit is acted on.
- One request in flight; ready_req_out=0 in every non-IDLE state.
- Latency with a same-cycle grant: accept at T, arb_req at T+1, read command on the bus at T+2, RD_WAIT at T+3.
- Reset:
  - While rst_n=1 at an edge: state goes to IDLE and all registers clear.
  - After reset: ready_req_out=1; arb_req=0; valid_compq_out=0; data_out=0; compq_data_out=0.
  - Reset mid-operation abandons the request and releases arb_req on the next edge.

Decomposition:
- Shared package: the state enum, the opcode constants MEM_READ=2'b01 and MEM_WRITE=2'b10, the ack bit indices (ACK_RD=0, ACK_HASH=1, ACK_WR=2), and the header field positions.
- Single module; no sub-module needed.

Test Plan:
- Reset held 2 cycles, then released -> ready_req_out=1, arb_req=0, valid_compq_out=0, data_out=0.
- Full flow:
  - Stimulus: req_data={2'b10, dest 24'h00ABCD, src 24'h001234}, immediate grant, ack bits 0/1/2 each pulsed once in turn, comq_ready_in=1.
  - Expected data_out: 32'h5800_1234 in RD_SEND, then 32'h9800_ABCD in WR_SEND.
  - Expected completion: valid_compq_out=1 with compq_data_out=24'h00ABCD, then back to IDLE.
- Grant delayed 5 cycles -> arb_req stays 1, data_out stays 0 until the cycle after the grant; the command lasts exactly 1 cycle.
- Ack ordering: ack_in=3'b110 during RD_WAIT -> no transition. ack_in=3'b001 -> HASH_WAIT. An early ack_in[1] pulse is lost, and the FSM waits for a new one.
- Completion backpressure: comq_ready_in=0 for 4 cycles -> valid/data held and ready_req_out=0; comq_ready_in=1 -> IDLE next cycle.
- Reset asserted in HASH_WAIT -> IDLE with arb_req=0 and valid_compq_out=0; a new request is accepted normally.

Source files
------------

// File: rtl/sha_fsm_pkg.sv
// Shared definitions for the SHA accelerator control sequencer.
package sha_fsm_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRdArb,
        StRdSend,
        StRdWait,
        StHashWait,
        StWrArb,
        StWrSend,
        StWrWait,
        StComplete
    } state_t;

    // Bus command opcodes
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // Bit positions within ack_in
    localparam int unsigned ACK_RD   = 0;
    localparam int unsigned ACK_HASH = 1;
    localparam int unsigned ACK_WR   = 2;

    // Header field LSB positions; each field is 2 bits wide, [1:0] is reserved zero
    localparam int unsigned HDR_OP_LSB   = 6;
    localparam int unsigned HDR_ID_LSB   = 4;
    localparam int unsigned HDR_CTRL_LSB = 2;

    function automatic logic [7:0] make_header(logic [1:0] op, logic [1:0] id, logic [1:0] ctrl);
        logic [7:0] hdr;
        hdr = '0;
        hdr[HDR_OP_LSB +: 2]   = op;
        hdr[HDR_ID_LSB +: 2]   = id;
        hdr[HDR_CTRL_LSB +: 2] = ctrl;
        return hdr;
    endfunction

endpackage

// File: rtl/sha_fsm.sv
// Sequencer for one SHA accelerator: request -> bus read -> hash -> write-back -> completion.
module sha_fsm
    import sha_fsm_pkg::*;
#(
    parameter int unsigned ADDRW    = 24,
    parameter logic [1:0]  ACCEL_ID = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst_n,  // active-high despite the name
    input  logic                 req_valid,
    input  logic [2*ADDRW+1:0]   req_data,
    output logic                 ready_req_out,
    input  logic                 comq_ready_in,
    output logic [ADDRW-1:0]     compq_data_out,
    output logic                 valid_compq_out,
    output logic                 arb_req,
    input  logic                 arb_grant,
    input  logic [2:0]           ack_in,
    output logic [ADDRW+7:0]     data_out
);

    state_t           state_q, state_d;
    logic [ADDRW-1:0] src_q;
    logic [ADDRW-1:0] dest_q;
    logic [1:0]       ctrl_q;

    // Next-state logic; grant and acks only matter in the state that waits for them
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (req_valid)        state_d = StRdArb;
            StRdArb:    if (arb_grant)        state_d = StRdSend;
            StRdSend:                         state_d = StRdWait;
            StRdWait:   if (ack_in[ACK_RD])   state_d = StHashWait;
            StHashWait: if (ack_in[ACK_HASH]) state_d = StWrArb;
            StWrArb:    if (arb_grant)        state_d = StWrSend;
            StWrSend:                         state_d = StWrWait;
            StWrWait:   if (ack_in[ACK_WR])   state_d = StComplete;
            StComplete: if (comq_ready_in)    state_d = StIdle;
            default:                          state_d = StIdle;
        endcase
    end

    // State, request latches and Moore outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q         <= StIdle;
            src_q           <= '0;
            dest_q          <= '0;
            ctrl_q          <= '0;
            ready_req_out   <= 1'b1;
            arb_req         <= 1'b0;
            valid_compq_out <= 1'b0;
            data_out        <= '0;
            compq_data_out  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                src_q  <= req_data[ADDRW-1:0];
                dest_q <= req_data[2*ADDRW-1:ADDRW];
                ctrl_q <= req_data[2*ADDRW+1:2*ADDRW];
            end
            ready_req_out   <= (state_d == StIdle);
            arb_req         <= (state_d inside {StRdArb, StRdSend, StWrArb, StWrSend});
            valid_compq_out <= (state_d == StComplete);
            // Latched fields are always settled before a SEND or COMPLETE state is entered
            data_out        <= '0;
            compq_data_out  <= '0;
            if (state_d == StRdSend) begin
                data_out <= {make_header(MEM_READ, ACCEL_ID, ctrl_q), src_q};
            end
            if (state_d == StWrSend) begin
                data_out <= {make_header(MEM_WRITE, ACCEL_ID, ctrl_q), dest_q};
            end
            if (state_d == StComplete) begin
                compq_data_out <= dest_q;
            end
        end
    end

endmodule

// File: tb/tb_sha_fsm.sv
// Directed self-checking bench for sha_fsm with a scoreboard of expected bus commands.
module tb_sha_fsm;

    localparam int unsigned ADDRW = 24;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic [2*ADDRW+1:0] req_data;
    logic               ready_req_out;
    logic               comq_ready_in;
    logic [ADDRW-1:0]   compq_data_out;
    logic               valid_compq_out;
    logic               arb_req;
    logic               arb_grant;
    logic [2:0]         ack_in;
    logic [ADDRW+7:0]   data_out;

    logic [ADDRW+7:0] exp_cmd_q[$];
    logic [ADDRW-1:0] exp_comp_q[$];
    logic [ADDRW-1:0] exp_dest;
    int checks = 0;
    int errors = 0;

    sha_fsm #(.ADDRW(ADDRW), .ACCEL_ID(2'b01)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .ready_req_out   (ready_req_out),
        .comq_ready_in   (comq_ready_in),
        .compq_data_out  (compq_data_out),
        .valid_compq_out (valid_compq_out),
        .arb_req         (arb_req),
        .arb_grant       (arb_grant),
        .ack_in          (ack_in),
        .data_out        (data_out)
    );

    always #5 clk = ~clk;

    // Reference command word: {opcode, accel id 01, ctrl, 00, addr}
    function automatic logic [ADDRW+7:0] cmd(logic [1:0] op, logic [1:0] ctrl,
                                             logic [ADDRW-1:0] addr);
        return {op, 2'b01, ctrl, 2'b00, addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cmd(string tag);
        logic [ADDRW+7:0] e;
        if (exp_cmd_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 64'(exp_cmd_q.size()), 64'd1);
        end else begin
            e = exp_cmd_q.pop_front();
            chk(tag, 64'(data_out), 64'(e));
        end
    endtask

    task automatic drive_req(logic [1:0] ctrl, logic [ADDRW-1:0] dest, logic [ADDRW-1:0] src,
                             logic [ADDRW+7:0] exp_rd, logic [ADDRW+7:0] exp_wr);
        req_valid = 1'b1;
        req_data  = {ctrl, dest, src};
        exp_cmd_q.push_back(exp_rd);
        exp_cmd_q.push_back(exp_wr);
        exp_comp_q.push_back(dest);
        tick();
        req_valid = 1'b0;
        req_data  = '0;
    endtask

    task automatic pulse_ack(logic [2:0] a);
        ack_in = a;
        tick();
        ack_in = 3'b000;
    endtask

    // Complete transaction with immediate grants and a ready completion queue
    task automatic run_full(string tag, logic [1:0] ctrl, logic [ADDRW-1:0] dest,
                            logic [ADDRW-1:0] src, logic [ADDRW+7:0] exp_rd,
                            logic [ADDRW+7:0] exp_wr);
        comq_ready_in = 1'b1;
        arb_grant     = 1'b1;
        drive_req(ctrl, dest, src, exp_rd, exp_wr);
        chk({tag, "_rdarb_ready"}, 64'(ready_req_out), 64'd0);
        chk({tag, "_rdarb_req"}, 64'(arb_req), 64'd1);
        chk({tag, "_rdarb_data"}, 64'(data_out), 64'd0);
        tick();
        chk_cmd({tag, "_rd_cmd"});
        chk({tag, "_rdsend_req"}, 64'(arb_req), 64'd1);
        tick();
        chk({tag, "_rdwait_data"}, 64'(data_out), 64'd0);
        chk({tag, "_rdwait_req"}, 64'(arb_req), 64'd0);
        pulse_ack(3'b001);
        chk({tag, "_hash_req"}, 64'(arb_req), 64'd0);
        pulse_ack(3'b010);
        chk({tag, "_wrarb_req"}, 64'(arb_req), 64'd1);
        chk({tag, "_wrarb_data"}, 64'(data_out), 64'd0);
        tick();
        chk_cmd({tag, "_wr_cmd"});
        arb_grant = 1'b0;
        tick();
        chk({tag, "_wrwait_data"}, 64'(data_out), 64'd0);
        chk({tag, "_wrwait_req"}, 64'(arb_req), 64'd0);
        pulse_ack(3'b100);
        exp_dest = exp_comp_q.pop_front();
        chk({tag, "_comp_valid"}, 64'(valid_compq_out), 64'd1);
        chk({tag, "_comp_data"}, 64'(compq_data_out), 64'(exp_dest));
        chk({tag, "_comp_ready"}, 64'(ready_req_out), 64'd0);
        tick();
        chk({tag, "_idle_valid"}, 64'(valid_compq_out), 64'd0);
        chk({tag, "_idle_ready"}, 64'(ready_req_out), 64'd1);
        chk({tag, "_idle_cdata"}, 64'(compq_data_out), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b1;
        req_valid     = 1'b0;
        req_data      = '0;
        comq_ready_in = 1'b0;
        arb_grant     = 1'b0;
        ack_in        = 3'b000;

        // Reset held two cycles
        tick();
        tick();
        rst_n = 1'b0;
        chk("rst_ready", 64'(ready_req_out), 64'd1);
        chk("rst_arb", 64'(arb_req), 64'd0);
        chk("rst_valid", 64'(valid_compq_out), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_cdata", 64'(compq_data_out), 64'd0);
        tick();
        chk("idle_hold_ready", 64'(ready_req_out), 64'd1);

        // Full flow with fixed expected command words
        run_full("full", 2'b10, 24'h00ABCD, 24'h001234, 32'h5800_1234, 32'h9800_ABCD);

        // Grant delayed by five cycles
        arb_grant = 1'b0;
        drive_req(2'b01, 24'h000777, 24'h000055, cmd(2'b01, 2'b01, 24'h000055),
                  cmd(2'b10, 2'b01, 24'h000777));
        for (int i = 0; i < 5; i++) begin
            chk("dly_arb", 64'(arb_req), 64'd1);
            chk("dly_data", 64'(data_out), 64'd0);
            tick();
        end
        arb_grant = 1'b1;
        chk("dly_pre_grant_data", 64'(data_out), 64'd0);
        tick();
        chk_cmd("dly_rd_cmd");
        arb_grant = 1'b0;
        tick();
        chk("dly_cmd_one_cycle", 64'(data_out), 64'd0);

        // Ack ordering in RD_WAIT: wrong/early bits are ignored
        pulse_ack(3'b110);
        chk("ord_110_arb", 64'(arb_req), 64'd0);
        pulse_ack(3'b010);
        chk("ord_early_hash_arb", 64'(arb_req), 64'd0);
        pulse_ack(3'b001);
        for (int i = 0; i < 3; i++) begin
            chk("ord_hash_wait_arb", 64'(arb_req), 64'd0);
            tick();
        end
        pulse_ack(3'b010);
        chk("ord_wrarb_arb", 64'(arb_req), 64'd1);
        arb_grant = 1'b1;
        tick();
        chk_cmd("ord_wr_cmd");
        arb_grant = 1'b0;
        tick();

        // Completion backpressure
        comq_ready_in = 1'b0;
        pulse_ack(3'b100);
        exp_dest = exp_comp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 64'(valid_compq_out), 64'd1);
            chk("bp_cdata", 64'(compq_data_out), 64'(exp_dest));
            chk("bp_ready", 64'(ready_req_out), 64'd0);
            tick();
        end
        comq_ready_in = 1'b1;
        chk("bp_release_valid", 64'(valid_compq_out), 64'd1);
        tick();
        chk("bp_idle_valid", 64'(valid_compq_out), 64'd0);
        chk("bp_idle_ready", 64'(ready_req_out), 64'd1);

        // Reset while in HASH_WAIT
        arb_grant = 1'b1;
        drive_req(2'b00, 24'h111111, 24'h222222, cmd(2'b01, 2'b00, 24'h222222),
                  cmd(2'b10, 2'b00, 24'h111111));
        tick();
        chk_cmd("rmid_rd_cmd");
        arb_grant = 1'b0;
        tick();
        pulse_ack(3'b001);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("rmid_ready", 64'(ready_req_out), 64'd1);
        chk("rmid_arb", 64'(arb_req), 64'd0);
        chk("rmid_valid", 64'(valid_compq_out), 64'd0);
        chk("rmid_data", 64'(data_out), 64'd0);
        // The abandoned request never produces its write command or completion
        void'(exp_cmd_q.pop_front());
        void'(exp_comp_q.pop_front());

        run_full("post_rst", 2'b11, 24'hFEDCBA, 24'h0F0F0F, cmd(2'b01, 2'b11, 24'h0F0F0F),
                 cmd(2'b10, 2'b11, 24'hFEDCBA));

        chk("sb_cmd_empty", 64'(exp_cmd_q.size()), 64'd0);
        chk("sb_comp_empty", 64'(exp_comp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
